// File: rtl/a2d_spi_intf_if.sv
// Handshake between dig_core's motion block and the A2D SPI responder:
// conversion request/channel in one direction, completion flag/result in the other.
interface a2d_spi_intf_if;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] A2D_res;

    modport master (
        output strt_cnv,
        output chnnl,
        input  cnv_cmplt,
        input  A2D_res
    );

    modport slave (
        input  strt_cnv,
        input  chnnl,
        output cnv_cmplt,
        output A2D_res
    );
endinterface

// File: rtl/a2d_spi_intf.sv
// A2D responder: on request runs two 16-bit SPI frames to an ADC128S-style converter
// and publishes the 12-bit result of the second frame with a held completion flag.
module a2d_spi_intf #(
    parameter int SCLK_DIV = 32
) (
    input  logic           clk,
    input  logic           rst,
    a2d_spi_intf_if.slave  a2d_bus,
    output logic           o_ss_n,
    output logic           o_sclk,
    output logic           o_mosi,
    input  logic           i_miso
);

    localparam int DIV_W = $clog2(SCLK_DIV);
    localparam logic [DIV_W-1:0] HALF_M1 = DIV_W'(SCLK_DIV / 2 - 1);
    localparam logic [DIV_W-1:0] FULL_M1 = DIV_W'(SCLK_DIV - 1);
    localparam logic [4:0]       LAST_BIT = 5'd16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FRM1 = 3'd1,
        ST_GAP  = 3'd2,
        ST_FRM2 = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t            r_state;
    logic [DIV_W-1:0]  r_div;
    logic [4:0]        r_bit_cnt;
    logic [15:0]       r_tx;
    // The converter's four leading bits shift straight through and are discarded
    logic [11:0]       r_rx;
    logic              r_ss_n;
    logic              r_sclk;
    logic              r_mosi;
    logic              r_cnv_cmplt;
    logic [11:0]       r_a2d_res;
    logic [15:0]       w_tx_new;
    logic [DIV_W-1:0]  w_div_next;

    assign w_tx_new   = {2'b00, a2d_bus.chnnl, 11'b000_0000_0000};
    assign w_div_next = (r_div == FULL_M1) ? {DIV_W{1'b0}} : r_div + 1'b1;

    // Conversion sequencer: acceptance, SCLK generation, shifting and completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_div       <= {DIV_W{1'b0}};
            r_bit_cnt   <= 5'd0;
            r_tx        <= 16'h0000;
            r_rx        <= 12'h000;
            r_ss_n      <= 1'b1;
            r_sclk      <= 1'b1;
            r_mosi      <= 1'b0;
            r_cnv_cmplt <= 1'b0;
            r_a2d_res   <= 12'h000;
        end else begin
            case (r_state)
                // DONE only marks the completion edge; it accepts requests like IDLE
                ST_IDLE, ST_DONE: begin
                    if (a2d_bus.strt_cnv) begin
                        r_tx        <= w_tx_new;
                        r_ss_n      <= 1'b0;
                        r_mosi      <= w_tx_new[15];
                        r_cnv_cmplt <= 1'b0;
                        r_div       <= {DIV_W{1'b0}};
                        r_bit_cnt   <= 5'd0;
                        r_rx        <= 12'h000;
                        r_state     <= ST_FRM1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_FRM1, ST_FRM2: begin
                    r_div <= w_div_next;
                    if (r_div == HALF_M1) begin
                        if (r_bit_cnt == LAST_BIT) begin
                            r_ss_n    <= 1'b1;
                            r_mosi    <= 1'b0;
                            r_div     <= {DIV_W{1'b0}};
                            r_bit_cnt <= 5'd0;
                            if (r_state == ST_FRM1) begin
                                r_state <= ST_GAP;
                            end else begin
                                r_a2d_res   <= r_rx;
                                r_cnv_cmplt <= 1'b1;
                                r_state     <= ST_DONE;
                            end
                        end else begin
                            r_sclk <= 1'b0;
                            // The first fall precedes any sample, so bit 15 is kept
                            if (r_bit_cnt != 5'd0) begin
                                r_mosi <= r_tx[4'd15 - r_bit_cnt[3:0]];
                            end else begin
                                r_mosi <= r_mosi;
                            end
                        end
                    end else if (r_div == FULL_M1) begin
                        r_sclk    <= 1'b1;
                        r_rx      <= {r_rx[10:0], i_miso};
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                    end else begin
                        r_sclk <= r_sclk;
                    end
                end
                ST_GAP: begin
                    r_div <= w_div_next;
                    if (r_div == FULL_M1) begin
                        r_ss_n    <= 1'b0;
                        r_mosi    <= r_tx[15];
                        r_div     <= {DIV_W{1'b0}};
                        r_bit_cnt <= 5'd0;
                        r_state   <= ST_FRM2;
                    end else begin
                        r_state <= ST_GAP;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_ss_n            = r_ss_n;
    assign o_sclk            = r_sclk;
    assign o_mosi            = r_mosi;
    assign a2d_bus.cnv_cmplt = r_cnv_cmplt;
    assign a2d_bus.A2D_res   = r_a2d_res;

endmodule
